// File: rtl/pin_bus_pkg.sv
// Shared definitions for pin_if bus users: arbiter state encoding,
// transfer direction encoding and default bus widths.
package pin_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DW         = 8;

endpackage

// File: rtl/pin_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first set request bit
// found searching upward (circularly) from last_grant+1.
module rr_priority_picker #(
  parameter  int NM = 4,
  localparam int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] winner,
  output logic          valid
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write,
    // otherwise an unassigned path infers a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int off = NM; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NM;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_bus_arbiter.sv
// Round-robin arbiter sharing one pin_if slave port between NM masters.
// One transaction in flight; the winner's command is latched for the
// whole transfer and the completion (ack/err/rd_data) goes back to the
// winner only. A watchdog error-completes transfers the slave ignores.
module pin_bus_arbiter
  import pin_bus_pkg::*;
#(
  parameter int NM         = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DW         = DEF_DW,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NM-1:0]            m_req,
  input  logic [NM-1:0]            m_rw,
  input  logic [NM*ADDR_WIDTH-1:0] m_address,
  input  logic [NM*DW-1:0]         m_wr_data,
  output logic [DW-1:0]            m_rd_data,
  output logic [NM-1:0]            m_ack,
  output logic [NM-1:0]            m_err,
  output logic [ADDR_WIDTH-1:0]    s_address,
  output logic [DW-1:0]            s_wr_data,
  output logic                     s_rw,
  output logic                     s_req,
  input  logic [DW-1:0]            s_rd_data,
  input  logic                     s_ack,
  input  logic                     s_err,
  output logic [$clog2(NM)-1:0]    grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NM);
  // A disabled watchdog (TIMEOUT=0) still needs a legal 1-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] s_address_q, s_address_d;
  logic [DW-1:0]         s_wr_data_q, s_wr_data_d;
  logic                  s_rw_q, s_rw_d;
  logic                  s_req_q, s_req_d;
  logic [NM-1:0]         m_ack_q, m_ack_d;
  logic [NM-1:0]         m_err_q, m_err_d;
  logic [DW-1:0]         m_rd_data_q, m_rd_data_d;
  logic                  busy_q, busy_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  rr_priority_picker #(.NM(NM)) u_picker (
    .req        (m_req),
    .last_grant (last_q),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  // Next-state and registered-output logic for the IDLE/BUSY/RELEASE FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    s_address_d = s_address_q;
    s_wr_data_d = s_wr_data_q;
    s_rw_d      = s_rw_q;
    s_req_d     = s_req_q;
    m_rd_data_d = m_rd_data_q;
    busy_d      = busy_q;
    // Completion flags default low so they only ever pulse for one cycle.
    m_ack_d     = '0;
    m_err_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          s_address_d = m_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          s_wr_data_d = m_wr_data[pick_idx*DW +: DW];
          s_rw_d      = m_rw[pick_idx];
          s_req_d     = 1'b1;
          busy_d      = 1'b1;
          grant_d     = pick_idx;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Error beats ack when the slave reports both in the same cycle.
        if (s_err) begin
          s_req_d          = 1'b0;
          m_err_d[grant_q] = 1'b1;
          state_d          = RELEASE;
        end else if (s_ack) begin
          s_req_d          = 1'b0;
          m_ack_d[grant_q] = 1'b1;
          m_rd_data_d      = s_rd_data;
          state_d          = RELEASE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          s_req_d          = 1'b0;
          m_err_d[grant_q] = 1'b1;
          state_d          = RELEASE;
        end
      end
      RELEASE: begin
        // No arbitration here: the winner's stale request must not win again.
        busy_d  = 1'b0;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transfer without a completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(NM - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      s_address_q <= '0;
      s_wr_data_q <= '0;
      s_rw_q      <= RW_READ;
      s_req_q     <= 1'b0;
      m_ack_q     <= '0;
      m_err_q     <= '0;
      m_rd_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      s_address_q <= s_address_d;
      s_wr_data_q <= s_wr_data_d;
      s_rw_q      <= s_rw_d;
      s_req_q     <= s_req_d;
      m_ack_q     <= m_ack_d;
      m_err_q     <= m_err_d;
      m_rd_data_q <= m_rd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign s_address = s_address_q;
  assign s_wr_data = s_wr_data_q;
  assign s_rw      = s_rw_q;
  assign s_req     = s_req_q;
  assign m_ack     = m_ack_q;
  assign m_err     = m_err_q;
  assign m_rd_data = m_rd_data_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pin_bus_arbiter.sv
// Self-checking bench for pin_bus_arbiter: a transaction-level model
// predicts every registered output each cycle, directed scenarios pin
// the model with literal expectations, then a randomized phase runs.
module tb_pin_bus_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NM-1:0]    m_req = '0;
  logic [NM-1:0]    m_rw = '0;
  logic [NM*AW-1:0] m_address = '0;
  logic [NM*DW-1:0] m_wr_data = '0;
  logic [DW-1:0]    m_rd_data;
  logic [NM-1:0]    m_ack, m_err;
  logic [AW-1:0]    s_address;
  logic [DW-1:0]    s_wr_data;
  logic             s_rw, s_req;
  logic [DW-1:0]    s_rd_data = '0;
  logic             s_ack = 1'b0;
  logic             s_err = 1'b0;
  logic [1:0]       grant_id;
  logic             busy;

  pin_bus_arbiter #(.NM(NM), .ADDR_WIDTH(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_rw(m_rw), .m_address(m_address), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_ack(m_ack), .m_err(m_err),
    .s_address(s_address), .s_wr_data(s_wr_data), .s_rw(s_rw), .s_req(s_req),
    .s_rd_data(s_rd_data), .s_ack(s_ack), .s_err(s_err),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One open transaction at most; after it completes there is one dead
  // cycle before the next winner is chosen round-robin from the last one.
  bit            mv = 1'b0;
  bit            txn_open, draining;
  int            who, age, last_winner, w;
  logic [NM-1:0] e_ack, e_err;
  logic [DW-1:0] e_rd, e_wd;
  logic [AW-1:0] e_addr;
  logic          e_rw, e_req, e_busy;
  int            e_gid;

  function automatic int rr_pick(input logic [NM-1:0] r, input int last);
    for (int k = 1; k <= NM; k++)
      if (r[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mv = 1'b1; txn_open = 1'b0; draining = 1'b0; last_winner = NM - 1;
      e_ack = '0; e_err = '0; e_rd = '0; e_wd = '0; e_addr = '0;
      e_rw = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_gid = 0; who = 0; age = 0;
    end else if (mv) begin
      if (draining) begin
        draining = 1'b0; e_ack = '0; e_err = '0; e_busy = 1'b0; last_winner = who;
      end else if (txn_open) begin
        if (s_err || s_ack || age == TO - 1) begin
          txn_open = 1'b0; draining = 1'b1; e_req = 1'b0;
          if (s_err || !s_ack) e_err[who] = 1'b1;
          else begin e_ack[who] = 1'b1; e_rd = s_rd_data; end
        end else age++;
      end else begin
        w = rr_pick(m_req, last_winner);
        if (w >= 0) begin
          txn_open = 1'b1; who = w; age = 0; e_gid = w;
          e_addr = m_address[w*AW +: AW]; e_wd = m_wr_data[w*DW +: DW];
          e_rw = m_rw[w]; e_req = 1'b1; e_busy = 1'b1;
        end
      end
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (mv) begin
        check("s_req", s_req, e_req);
        check("busy", busy, e_busy);
        check("m_ack", m_ack, e_ack);
        check("m_err", m_err, e_err);
        check("m_rd_data", m_rd_data, e_rd);
        check("grant_id", grant_id, e_gid);
        check("s_address", s_address, e_addr);
        check("s_wr_data", s_wr_data, e_wd);
        check("s_rw", s_rw, e_rw);
      end
    end
  endtask

  // ---------------- slave responder ----------------
  // kind: 0 ack, 1 err, 2 ack+err together, 3 silent
  bit         sl_rand = 1'b0;
  bit         spurious_on = 1'b0;
  int         sl_delay = 0;
  int         sl_kind = 0;
  logic [DW-1:0] sl_rd = '0;

  task automatic slave_loop();
    int age_s = 0;
    int r;
    forever begin
      @(posedge clk);
      #1;
      s_ack = 1'b0; s_err = 1'b0;
      if (s_req) begin
        if (age_s == 0 && sl_rand) begin
          sl_delay = $urandom_range(0, 5);
          r = $urandom_range(0, 19);
          sl_kind = (r < 12) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : 3;
        end
        if (age_s == sl_delay && sl_kind != 3) begin
          s_ack = (sl_kind == 0 || sl_kind == 2);
          s_err = (sl_kind == 1 || sl_kind == 2);
          s_rd_data = sl_rand ? DW'($urandom) : sl_rd;
        end
        age_s++;
      end else begin
        age_s = 0;
        if (spurious_on && $urandom_range(0, 7) == 0) begin
          s_ack = 1'($urandom); s_err = 1'($urandom); s_rd_data = DW'($urandom);
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (|m_ack || |m_err) ok = 1'b1;
    end
    if (!ok) check("completion_wait_expired", 0, 1);
  endtask

  task automatic wait_sreq(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (s_req) ok = 1'b1;
    end
    if (!ok) check("s_req_wait_expired", 0, 1);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    bit ok;
    int n;
    fork
      compare_loop();
      slave_loop();
    join_none

    // Single read through requester 1, slave answers after two cycles.
    do_reset();
    sl_kind = 0; sl_delay = 2; sl_rd = 8'hA5;
    m_address[1*AW +: AW] = 16'h1234; m_rw[1] = 1'b0; m_req = 4'b0010;
    wait_sreq(10, ok);
    check("t1_s_address", s_address, 16'h1234);
    wait_done(20, ok);
    check("t1_ack", m_ack, 4'b0010);
    check("t1_rd_data", m_rd_data, 8'hA5);
    m_req = '0;
    @(negedge clk);
    check("t1_ack_one_cycle", m_ack, 4'b0000);

    // Round-robin with all four holding requests, immediate slave.
    do_reset();
    sl_kind = 0; sl_delay = 0; m_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, ok);
      check("rr_grant", grant_id, rr_exp[k]);
    end
    m_req = '0;

    // Late arrival: requester 3 joins once 2 has been served.
    do_reset();
    m_req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      wait_done(20, ok);
      check("late_grant", grant_id, k);
    end
    m_req = 4'b1111;
    wait_done(20, ok);
    check("late_grant_3", grant_id, 3);
    m_req = '0;

    // Watchdog: silent slave on requester 0, requester 1 served afterwards.
    do_reset();
    sl_kind = 3; m_req = 4'b0011;
    wait_sreq(10, ok);
    n = 0;
    while (s_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("to_sreq_cycles", n, TO);
    check("to_err", m_err, 4'b0001);
    check("to_no_ack", m_ack, 4'b0000);
    m_req = 4'b0010; sl_kind = 0; sl_delay = 1;
    wait_done(20, ok);
    check("to_next_ack", m_ack, 4'b0010);
    m_req = '0;

    // Simultaneous ack and err on a write from requester 2.
    do_reset();
    m_address[2*AW +: AW] = 16'h00FF; m_wr_data[2*DW +: DW] = 8'h5A; m_rw[2] = 1'b1;
    sl_kind = 2; sl_delay = 3; m_req = 4'b0100;
    wait_sreq(10, ok);
    n = 0;
    while (s_req && n < 20) begin
      check("both_wr_data", s_wr_data, 8'h5A);
      check("both_rw", s_rw, 1'b1);
      n++;
      @(negedge clk);
    end
    check("both_err", m_err, 4'b0100);
    check("both_no_ack", m_ack, 4'b0000);
    m_req = '0;

    // Reset three cycles into a transfer aborts it silently.
    do_reset();
    sl_kind = 3; m_req = 4'b0010;
    wait_sreq(10, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_s_req", s_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", m_ack, 4'b0000);
    check("rst_err", m_err, 4'b0000);
    check("rst_grant_id", grant_id, 0);
    check("rst_s_address", s_address, 16'h0000);
    rst = 1'b0;
    m_req = 4'b1001; sl_kind = 0; sl_delay = 0;
    wait_done(20, ok);
    check("rst_first_grant", grant_id, 0);
    check("rst_first_ack", m_ack, 4'b0001);
    m_req = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic, slave behaviour, spurious responses and resets.
    sl_rand = 1'b1; spurious_on = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NM; i++) begin
        if (m_req[i] && (m_ack[i] || m_err[i])) m_req[i] = 1'b0;
        else if (m_req[i] && $urandom_range(0, 63) == 0) m_req[i] = 1'b0;
        else if (!m_req[i] && $urandom_range(0, 3) == 0) begin
          m_req[i] = 1'b1;
          m_rw[i] = 1'($urandom);
          m_address[i*AW +: AW] = AW'($urandom);
          m_wr_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end
    rst = 1'b0; m_req = '0; sl_rand = 1'b0; sl_kind = 0; spurious_on = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
